// File: rtl/mc14500_sequencer.sv
// mc14500_sequencer: PC, ROM word split and JMP/call/RTN return stack for the MC14500 ICU.
// Optional SEQ_HALT_ON_NOPF_EN: NOPF with all-ones operand parks the PC on itself until reset.
module mc14500_sequencer #(
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              icu_state,
  input  logic              skp_i,
  input  logic              jmp_i,
  input  logic              rtn_i,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [ADDR_W+4:0] prog_data,
  output logic [3:0]        I,
  output logic [ADDR_W-1:0] io_addr,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic              seq_err
`ifdef SEQ_HALT_ON_NOPF_EN
  ,
  output logic              halted
`endif
);
  localparam int SW = $clog2(STACK_DEPTH) + 1;
  logic [ADDR_W-1:0] pc, opnd_q, top;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [3:0] op_q;
  logic [SW-1:0] sp, sp_dn;
  logic call_q, valid, exp_jmp, exp_rtn, rtn_mask;
  logic do_jmp, do_rtn, full, empty, push, hlt_set, halt;
  assign prog_addr = pc;
  assign I = prog_data[3:0];
  assign do_jmp = icu_state && valid && op_q == 4'b1100;
  assign do_rtn = icu_state && valid && op_q == 4'b1101;
  assign full = sp == SW'(STACK_DEPTH);
  assign empty = sp == '0;
  assign push = do_jmp && call_q && !full;
  assign sp_dn = sp - SW'(1);
  assign top = stack[sp_dn[SW-2:0]];
`ifdef SEQ_HALT_ON_NOPF_EN
  logic halt_q;
  assign hlt_set = icu_state && valid && op_q == 4'b1111 && &opnd_q;
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) halt_q <= 1'b0;
    else if (hlt_set) halt_q <= 1'b1;
  assign halt = halt_q;
  assign halted = halt_q;
`else
  assign hlt_set = 1'b0;
  assign halt = 1'b0;
`endif
  // stack contents need no reset; sp alone defines what is live
  always_ff @(posedge clk_in)
    if (push) stack[sp[SW-2:0]] <= pc;
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      io_addr <= '0;
      opnd_q <= '0;
      op_q <= '0;
      call_q <= 1'b0;
      valid <= 1'b0;
      sp <= '0;
      exp_jmp <= 1'b0;
      exp_rtn <= 1'b0;
      rtn_mask <= 1'b0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      seq_err <= 1'b0;
    end else if (!icu_state) begin
      op_q <= prog_data[3:0];
      opnd_q <= prog_data[ADDR_W+3:4];
      call_q <= prog_data[ADDR_W+4];
      io_addr <= prog_data[ADDR_W+3:4];
      valid <= !skp_i;
      pc <= halt ? pc : pc + ADDR_W'(1);
      // the ICU holds RTN into the following FETCH, so that one is not compared
      rtn_mask <= exp_rtn;
      if (jmp_i != exp_jmp || (!rtn_mask && rtn_i != exp_rtn)) seq_err <= 1'b1;
    end else begin
      exp_jmp <= do_jmp;
      exp_rtn <= do_rtn;
      if (do_jmp) pc <= opnd_q;
      if (do_jmp && call_q) begin
        if (full) stk_ovf <= 1'b1;
        else sp <= sp + SW'(1);
      end
      if (do_rtn) begin
        if (empty) stk_unf <= 1'b1;
        else begin
          sp <= sp_dn;
          pc <= top;
        end
      end
      if (hlt_set && !halt) pc <= pc - ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_mc14500_sequencer.sv
// tb_mc14500_sequencer: directed vectors for the sequencer with the bench acting as ICU and ROM.
module tb_mc14500_sequencer;
  logic clk_in = 1'b0, rst = 1'b0, icu_state = 1'b0, skp_i = 1'b0, jmp_i = 1'b0, rtn_i = 1'b0;
  logic [7:0] prog_addr, io_addr;
  logic [12:0] prog_data;
  logic [3:0] I;
  logic stk_ovf, stk_unf, seq_err;
`ifdef SEQ_HALT_ON_NOPF_EN
  logic halted;
`endif
  logic [12:0] rom [256];
  int checks = 0, failures = 0;

  typedef struct {
    logic [2:0] f;
    logic [7:0] io;
    logic [7:0] pc;
    logic [1:0] e;
  } vec_t;
  vec_t tbl [29];

  assign prog_data = rom[prog_addr];
  always #5 clk_in = ~clk_in;

  mc14500_sequencer dut (
    .clk_in(clk_in), .rst(rst), .icu_state(icu_state), .skp_i(skp_i), .jmp_i(jmp_i),
    .rtn_i(rtn_i), .prog_addr(prog_addr), .prog_data(prog_data), .I(I), .io_addr(io_addr),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf), .seq_err(seq_err)
`ifdef SEQ_HALT_ON_NOPF_EN
    , .halted(halted)
`endif
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fetch(input logic [2:0] f);
    icu_state = 1'b0;
    {skp_i, jmp_i, rtn_i} = f;
    @(posedge clk_in);
    #1;
  endtask

  task automatic decode();
    icu_state = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  task automatic plain(input int n);
    repeat (n) begin
      fetch(3'b000);
      decode();
    end
  endtask

  task automatic async_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_pc", prog_addr, 8'h00);
    chk("rst_io", io_addr, 8'h00);
    chk("rst_ovf", {7'd0, stk_ovf}, 8'h00);
    chk("rst_unf", {7'd0, stk_unf}, 8'h00);
    chk("rst_err", {7'd0, seq_err}, 8'h00);
`ifdef SEQ_HALT_ON_NOPF_EN
    chk("rst_halted", {7'd0, halted}, 8'h00);
`endif
    @(posedge clk_in);
    #1;
    rst = 1'b1;
    icu_state = 1'b0;
    {skp_i, jmp_i, rtn_i} = 3'b000;
  endtask

  initial begin
    logic [7:0] a8, e8;
    for (int a = 0; a < 256; a++) begin
      a8 = 8'(a);
      rom[a] = {1'b0, ~a8, 4'h1};
    end
    repeat (2) @(posedge clk_in);
    #1;
    chk("init_pc", prog_addr, 8'h00);
    chk("init_io", io_addr, 8'h00);
    chk("init_flags", {5'd0, stk_ovf, stk_unf, seq_err}, 8'h00);
    rst = 1'b1;
    // straight-line program: PC walks and wraps, io_addr follows each operand
    for (int i = 0; i < 300; i++) begin
      a8 = 8'(i);
      e8 = ~a8;
      chk("walk_pc", prog_addr, a8);
      chk("walk_I", {4'h0, I}, 8'h01);
      fetch(3'b000);
      chk("walk_io", io_addr, e8);
      decode();
    end
    chk("walk_flags", {5'd0, stk_ovf, stk_unf, seq_err}, 8'h00);
`ifdef SEQ_HALT_ON_NOPF_EN
    async_reset();
    rom[8'h30] = {1'b0, 8'hFF, 4'hF};
    plain(48);
    chk("halt_pre_pc", prog_addr, 8'h30);
    fetch(3'b000);
    chk("halt_io", io_addr, 8'hFF);
    decode();
    chk("halt_set", {7'd0, halted}, 8'h01);
    chk("halt_pc", prog_addr, 8'h30);
    repeat (50) begin
      fetch(3'b000);
      decode();
      chk("halt_hold_pc", prog_addr, 8'h30);
    end
    chk("halt_err", {7'd0, seq_err}, 8'h00);
    rom[8'h30] = {1'b0, 8'hCF, 4'h1};
`endif
    async_reset();
    rom[8'h10] = {1'b1, 8'h40, 4'hC};
    rom[8'h45] = {1'b0, 8'h00, 4'hD};
    rom[8'h13] = {1'b0, 8'h20, 4'hC};
    rom[8'h20] = {1'b0, 8'hDF, 4'hE};
    rom[8'h21] = {1'b0, 8'h80, 4'hC};
    rom[8'h23] = {1'b0, 8'h50, 4'hC};
    for (int k = 0; k < 5; k++) begin
      a8 = 8'(8'h54 + 4 * k);
      rom[8'h50 + 4 * k] = {1'b1, a8, 4'hC};
      rom[8'h52 + 4 * k] = {1'b0, 8'h00, 4'hD};
    end
    rom[8'h64] = {1'b0, 8'h00, 4'hD};
    // f = {skp_i, jmp_i, rtn_i} as the ICU presents them; e = {stk_ovf, stk_unf} after decode
    tbl[0]  = '{3'b000, 8'h40, 8'h40, 2'b00};
    tbl[1]  = '{3'b010, 8'hBF, 8'h41, 2'b00};
    tbl[2]  = '{3'b000, 8'hBE, 8'h42, 2'b00};
    tbl[3]  = '{3'b000, 8'hBD, 8'h43, 2'b00};
    tbl[4]  = '{3'b000, 8'hBC, 8'h44, 2'b00};
    tbl[5]  = '{3'b000, 8'hBB, 8'h45, 2'b00};
    tbl[6]  = '{3'b000, 8'h00, 8'h11, 2'b00};
    tbl[7]  = '{3'b101, 8'hEE, 8'h12, 2'b00};
    tbl[8]  = '{3'b001, 8'hED, 8'h13, 2'b00};
    tbl[9]  = '{3'b000, 8'h20, 8'h20, 2'b00};
    tbl[10] = '{3'b010, 8'hDF, 8'h21, 2'b00};
    tbl[11] = '{3'b100, 8'h80, 8'h22, 2'b00};
    tbl[12] = '{3'b000, 8'hDD, 8'h23, 2'b00};
    tbl[13] = '{3'b000, 8'h50, 8'h50, 2'b00};
    tbl[14] = '{3'b010, 8'h54, 8'h54, 2'b00};
    tbl[15] = '{3'b010, 8'h58, 8'h58, 2'b00};
    tbl[16] = '{3'b010, 8'h5C, 8'h5C, 2'b00};
    tbl[17] = '{3'b010, 8'h60, 8'h60, 2'b00};
    tbl[18] = '{3'b010, 8'h64, 8'h64, 2'b10};
    tbl[19] = '{3'b010, 8'h00, 8'h5D, 2'b10};
    tbl[20] = '{3'b101, 8'hA2, 8'h5E, 2'b10};
    tbl[21] = '{3'b001, 8'h00, 8'h59, 2'b10};
    tbl[22] = '{3'b101, 8'hA6, 8'h5A, 2'b10};
    tbl[23] = '{3'b001, 8'h00, 8'h55, 2'b10};
    tbl[24] = '{3'b101, 8'hAA, 8'h56, 2'b10};
    tbl[25] = '{3'b001, 8'h00, 8'h51, 2'b10};
    tbl[26] = '{3'b101, 8'hAE, 8'h52, 2'b10};
    tbl[27] = '{3'b001, 8'h00, 8'h53, 2'b11};
    tbl[28] = '{3'b101, 8'hAC, 8'h54, 2'b11};
    plain(16);
    chk("pre_tbl_pc", prog_addr, 8'h10);
    for (int i = 0; i < 29; i++) begin
      fetch(tbl[i].f);
      chk($sformatf("tbl%0d_io", i), io_addr, tbl[i].io);
      decode();
      chk($sformatf("tbl%0d_pc", i), prog_addr, tbl[i].pc);
      chk($sformatf("tbl%0d_ovf", i), {7'd0, stk_ovf}, {7'd0, tbl[i].e[1]});
      chk($sformatf("tbl%0d_unf", i), {7'd0, stk_unf}, {7'd0, tbl[i].e[0]});
      chk($sformatf("tbl%0d_err", i), {7'd0, seq_err}, 8'h00);
    end
    // ICU claims a jump the sequencer did not decode
    fetch(3'b010);
    chk("bad_jmp_err", {7'd0, seq_err}, 8'h01);
    decode();
    async_reset();
    chk("post_rst_pc", prog_addr, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc14500_sequencer.md
Name: mc14500_sequencer

Overview:
- Program sequencer that sits directly upstream of the mc14500 ICU core.
- Owns the program counter and addresses an external combinational program ROM.
- Splits each program word into the 4-bit opcode (driven to the ICU's I input) and an operand that serves as both I/O address and jump target.
- Implements JMP, subroutine call and RTN with a return stack, in lockstep with the ICU's two-phase FETCH/DECODE_EXECUTE cycle.

Parameters:
ADDR_W, 8, program-address and operand width
STACK_DEPTH, 4, return-stack entries (power of two, >=2)
RESET_PC, 0, PC value after reset

Ports:
clk_in  input  1  clock, shared with the ICU
rst  input  1  asynchronous, active-low reset (0 = reset)
icu_state  input  1  ICU state_out; 0 = FETCH, 1 = DECODE_EXECUTE
skp_i  input  1  ICU SKP
jmp_i  input  1  ICU JMP flag
rtn_i  input  1  ICU RTN flag
prog_addr  output  ADDR_W  ROM address, equals PC
prog_data  input  ADDR_W+5  ROM word {call[ADDR_W+4], operand[ADDR_W+3:4], opcode[3:0]}
I  output  4  combinational prog_data[3:0], to ICU
io_addr  output  ADDR_W  registered operand of the current instruction
stk_ovf  output  1  sticky: push attempted on full stack
stk_unf  output  1  sticky: pop attempted on empty stack
seq_err  output  1  sticky: ICU JMP/RTN flags disagree with the sequencer's own decode

Behaviour:
- Reset (async, rst=0): PC=RESET_PC, io_addr=0, stack pointer=0, decode regs cleared, valid=0, expected-flag regs=0, stk_ovf=stk_unf=seq_err=0. Stack contents are don't-care.
- Lockstep: the sequencer tracks phase only through icu_state and keeps no phase FSM of its own. Both blocks come out of reset in FETCH.
- FETCH edge (icu_state=0):
  - latch opcode, operand and call into decode regs;
  - io_addr <= operand;
  - valid <= ~skp_i, because the ICU ignores I while skipping;
  - PC <= PC+1, which wraps from 2^ADDR_W-1 to 0 and happens even when skipping.
- DECODE edge (icu_state=1), only when valid=1:
  - opcode 4'b1100 (JMP): PC <= operand. If call=1, push the current PC (JMP address+1).
  - opcode 4'b1101 (RTN): pop; PC <= top-of-stack.
  - All other opcodes: PC unchanged.
- When valid=0, a DECODE edge does nothing.
- Latency: the target word appears on prog_addr in the FETCH cycle immediately after the JMP/RTN decode cycle. There is no bubble.
- RTN convention: the ICU skips the word at the return address (the word after the call). The programmer places a NOP there. The sequencer still increments past it.
- Stack full on push: push dropped, stk_ovf <= 1, jump still taken.
- Stack empty on pop: stk_unf <= 1, PC keeps its FETCH-incremented value (falls through).
- Flag check:
  - At a valid JMP/RTN decode edge, set exp_jmp/exp_rtn; at any other DECODE edge, clear them.
  - At each FETCH edge, if jmp_i != exp_jmp or rtn_i != exp_rtn, seq_err <= 1.
  - rtn_i is checked only on the first FETCH after RTN; the ICU holds RTN for two cycles.
- Push and pop never occur in the same cycle, since there is at most one instruction per DECODE edge.
- Reset asserted mid-instruction aborts it immediately; there is no pending push/pop afterwards.

Optional Feature:
SEQ_HALT_ON_NOPF_EN
- Defined:
  - A valid NOPF (4'b1111) with operand all-ones sets an internal halt bit at its DECODE edge.
  - While halted, the FETCH-edge increment is suppressed and PC re-points to the NOPF word, so the ICU re-executes it indefinitely.
  - JMP/RTN cannot occur while halted.
  - Only reset clears the halt bit.
  - A 1-bit output port halted is added (reset 0).
- Undefined: NOPF is an ordinary no-op for the sequencer; no halted port.

Test Plan:
1. Reset, ROM with no JMP/RTN, 300 ICU cycles (ADDR_W=8) -> prog_addr counts 0..255 then wraps to 0; io_addr tracks each operand one edge after fetch; all sticky flags 0.
2. Word at 0x10 = JMP operand 0x40 call=1 -> FETCH cycle after decode shows prog_addr=0x40; stack top=0x11; jmp_i high in that cycle; seq_err stays 0.
3. At 0x45 RTN following test 2 -> prog_addr=0x11 next FETCH; ICU skips 0x11 (valid=0, no decode); prog_addr=0x12 afterwards; stack empty.
4. SKZ with RR=0 preceding a JMP at 0x21 -> JMP skipped; PC continues 0x22; no push; exp_jmp=0; seq_err=0.
5. Five nested calls with STACK_DEPTH=4 -> stk_ovf=1 at 5th push, jump taken; five RTNs -> fifth sets stk_unf=1 and falls through; force jmp_i=1 on a non-JMP FETCH -> seq_err=1.
6. With SEQ_HALT_ON_NOPF_EN, NOPF operand 0xFF at 0x30 -> halted=1; prog_addr stuck at 0x30 for 50 cycles; async rst pulse mid-cycle -> PC=0, halted=0.
